// File: rtl/i2s_sched_pkg.sv
// Shared definitions for the I2S burst scheduler: header marker, FSM state
// encoding and the helper that builds the per-burst header word.
package i2s_sched_pkg;

    // Top nibble of every header word, lets the host spot burst boundaries
    localparam logic [3:0] HDR_MARKER = 4'hA;

    // Scheduler phases: wait for a grant, emit header, stream words, flush last word
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        READ   = 2'd2,
        DRAIN  = 2'd3
    } sched_state_e;

    // Header layout: marker in the top nibble, channel ID in the low bits,
    // zeros in between. Built 64 bits wide; the caller truncates to its data width.
    function automatic logic [63:0] pack_header(input int unsigned data_width,
                                                input logic [31:0] id);
        logic [63:0] hdr;
        hdr = (64'(HDR_MARKER) << (data_width - 32'd4)) | 64'(id);
        return hdr;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first requester found when scanning
// from last+1 upward, wrapping modulo N. Purely combinational, one cycle.
module rr_pick #(
    parameter int N  = 32,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic          valid,
    output logic [LW-1:0] idx
);

    localparam logic [LW:0] N_W = (LW + 1)'(N);

    logic [LW:0] pos_s;
    logic        hit_s;

    // Walk positions last+1 .. last+N (wrapped) and latch onto the first request seen
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos_s = '0;
        hit_s = 1'b0;
        for (int i = 1; i <= N; i++) begin
            pos_s = {1'b0, last} + (LW + 1)'(i);
            pos_s = (pos_s >= N_W) ? (pos_s - N_W) : pos_s;
            hit_s = !valid && req[pos_s[LW-1:0]];
            idx   = hit_s ? pos_s[LW-1:0] : idx;
            valid = valid | hit_s;
        end
    end

endmodule

// File: rtl/i2s_burst_scheduler.sv
// Round-robin burst scheduler: shares one downstream FIFO write port among
// NUM_SRC receiver channels. Each grant optionally emits a header word with
// the channel ID, then moves exactly BURST_LEN words from the granted channel.
// The read strobe pops the source head; the word sampled at the same edge is
// presented downstream in the following cycle.
module i2s_burst_scheduler
    import i2s_sched_pkg::*;
#(
    parameter int NUM_SRC    = 32,
    parameter int ID_WIDTH   = 5,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 15,
    parameter int HEADER_EN  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_mask,
    input  logic [NUM_SRC-1:0]            src_ready,
    output logic [NUM_SRC-1:0]            src_rd_en,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_rdata,
    input  logic                          dst_space_ok,
    output logic                          dst_wen,
    output logic [DATA_WIDTH-1:0]         dst_wdata,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           cur_id,
    output logic [31:0]                   burst_count
);

    localparam int LW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = $clog2(BURST_LEN);
    localparam logic [CW-1:0]       CNT_LAST  = CW'(BURST_LEN - 1);
    localparam logic [ID_WIDTH-1:0] LAST_INIT = ID_WIDTH'(NUM_SRC - 1);

    // Architectural state
    sched_state_e          state_r;
    logic [CW-1:0]         cnt_r;
    logic [ID_WIDTH-1:0]   cur_id_r;
    logic [ID_WIDTH-1:0]   last_grant_r;
    logic [31:0]           burst_count_r;

    // Registered outputs
    logic [NUM_SRC-1:0]    rd_en_r;
    logic                  wen_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  busy_r;

    // Next-state and next-output values
    sched_state_e          state_nx_s;
    logic [CW-1:0]         cnt_nx_s;
    logic [ID_WIDTH-1:0]   cur_id_nx_s;
    logic [NUM_SRC-1:0]    rd_en_nx_s;
    logic                  wen_nx_s;
    logic [DATA_WIDTH-1:0] wdata_nx_s;

    // Arbitration
    logic [NUM_SRC-1:0]    eligible_s;
    logic                  win_valid_s;
    logic [LW-1:0]         win_idx_s;
    logic [DATA_WIDTH-1:0] src_word_s;

    assign eligible_s = src_ready & src_mask;

    rr_pick #(
        .N  (NUM_SRC),
        .LW (LW)
    ) u_rr_pick (
        .req   (eligible_s),
        .last  (last_grant_r[LW-1:0]),
        .valid (win_valid_s),
        .idx   (win_idx_s)
    );

    // Select the granted channel's head word out of the flattened source bus
    always_comb begin
        src_word_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_word_s = (cur_id_r == ID_WIDTH'(i)) ? src_rdata[i*DATA_WIDTH +: DATA_WIDTH]
                                                    : src_word_s;
        end
    end

    // State register plus grant bookkeeping; a burst only counts once DRAIN completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            cur_id_r      <= '0;
            last_grant_r  <= LAST_INIT;
            burst_count_r <= 32'd0;
        end else begin
            state_r  <= state_nx_s;
            cnt_r    <= cnt_nx_s;
            cur_id_r <= cur_id_nx_s;
            if (state_r == DRAIN) begin
                last_grant_r  <= cur_id_r;
                burst_count_r <= burst_count_r + 32'd1;
            end else begin
                last_grant_r  <= last_grant_r;
                burst_count_r <= burst_count_r;
            end
        end
    end

    // Next-state logic: inputs are only looked at while IDLE, bursts always run to completion
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        cur_id_nx_s = cur_id_r;
        case (state_r)
            IDLE: begin
                cnt_nx_s = '0;
                if (win_valid_s && dst_space_ok) begin
                    cur_id_nx_s = ID_WIDTH'(win_idx_s);
                    state_nx_s  = (HEADER_EN != 0) ? HEADER : READ;
                end else begin
                    state_nx_s  = IDLE;
                end
            end
            HEADER: begin
                cnt_nx_s   = '0;
                state_nx_s = READ;
            end
            READ: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nx_s   = '0;
                    state_nx_s = DRAIN;
                end else begin
                    cnt_nx_s   = cnt_r + CW'(1);
                    state_nx_s = READ;
                end
            end
            DRAIN: begin
                cnt_nx_s   = '0;
                state_nx_s = IDLE;
            end
            default: begin
                cnt_nx_s   = '0;
                state_nx_s = IDLE;
            end
        endcase
    end

    // Output decode for the upcoming state, so the registered outputs line up with it
    always_comb begin
        rd_en_nx_s = '0;
        wen_nx_s   = 1'b0;
        wdata_nx_s = '0;
        case (state_nx_s)
            IDLE: begin
                wen_nx_s = 1'b0;
            end
            HEADER: begin
                wen_nx_s   = 1'b1;
                wdata_nx_s = DATA_WIDTH'(pack_header(DATA_WIDTH, 32'(cur_id_nx_s)));
            end
            READ: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    rd_en_nx_s[i] = (cur_id_nx_s == ID_WIDTH'(i));
                end
                // First READ cycle only pops; words follow one cycle behind the strobes
                wen_nx_s   = (cnt_nx_s != '0);
                wdata_nx_s = (cnt_nx_s != '0) ? src_word_s : '0;
            end
            DRAIN: begin
                wen_nx_s   = 1'b1;
                wdata_nx_s = src_word_s;
            end
            default: begin
                wen_nx_s = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears strobes immediately, aborting any partial burst
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_en_r <= '0;
            wen_r   <= 1'b0;
            wdata_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            rd_en_r <= rd_en_nx_s;
            wen_r   <= wen_nx_s;
            wdata_r <= wdata_nx_s;
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    assign src_rd_en   = rd_en_r;
    assign dst_wen     = wen_r;
    assign dst_wdata   = wdata_r;
    assign busy        = busy_r;
    assign cur_id      = cur_id_r;
    assign burst_count = burst_count_r;

endmodule

// File: tb/tb_i2s_burst_scheduler.sv
// Bench for i2s_burst_scheduler: a cycle-level reference model predicts every
// cycle's strobes, data, busy, cur_id and burst_count from the scheduling rules;
// a table of scenarios, hand-written corner sequences and random stimulus drive it.
module tb_i2s_burst_scheduler;

    localparam int NUM_SRC = 32;
    localparam int IDW     = 5;
    localparam int DW      = 16;
    localparam int BL      = 15;
    localparam int HEN     = 1;

    logic              clk;
    logic              rst_n;
    logic [31:0]       src_mask;
    logic [31:0]       src_ready;
    logic [31:0]       src_rd_en;
    logic [NUM_SRC*DW-1:0] src_rdata;
    logic              dst_space_ok;
    logic              dst_wen;
    logic [DW-1:0]     dst_wdata;
    logic              busy;
    logic [IDW-1:0]    cur_id;
    logic [31:0]       burst_count;

    i2s_burst_scheduler #(
        .NUM_SRC(NUM_SRC), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .BURST_LEN(BL), .HEADER_EN(HEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src_mask(src_mask), .src_ready(src_ready),
        .src_rd_en(src_rd_en), .src_rdata(src_rdata), .dst_space_ok(dst_space_ok),
        .dst_wen(dst_wen), .dst_wdata(dst_wdata), .busy(busy), .cur_id(cur_id),
        .burst_count(burst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Source channels: head word is a function of channel and pop count
    int src_ptr [NUM_SRC];
    initial begin
        for (int i = 0; i < NUM_SRC; i++) src_ptr[i] = 0;
    end

    function automatic logic [15:0] src_word(input int ch, input int ptr);
        return 16'((ch << 10) ^ (ptr * 37 + 11));
    endfunction

    always_comb begin
        src_rdata = '0;
        for (int i = 0; i < NUM_SRC; i++) src_rdata[i*DW +: DW] = src_word(i, src_ptr[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_rd_en[i]) src_ptr[i] <= src_ptr[i] + 1;
        end
    end

    // Reference model state: a queue of per-cycle expectations for the granted burst
    typedef struct {
        logic        wen;
        logic [15:0] wdata;
        int          rd_ch;
        logic        last;
    } exp_t;

    exp_t        m_q[$];
    int          m_ptr [NUM_SRC];
    int          m_last = NUM_SRC - 1;
    int          m_cur  = 0;
    logic [31:0] m_bc   = 32'd0;
    logic        m_busy = 1'b0;
    logic        m_lastflag = 1'b0;
    int          wen_seen = 0;

    initial begin
        for (int i = 0; i < NUM_SRC; i++) m_ptr[i] = 0;
    end

    function automatic int pick(input logic [31:0] elig, input int last);
        int c;
        for (int k = 1; k <= NUM_SRC; k++) begin
            c = (last + k) % NUM_SRC;
            if (elig[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs the DUT saw there
    task automatic model_edge();
        int   rem;
        int   ch;
        exp_t e;
        if (!rst_n) begin
            rem = 0;
            foreach (m_q[k]) rem += (m_q[k].rd_ch >= 0) ? 1 : 0;
            m_ptr[m_cur] -= rem;
            m_q.delete();
            m_last = NUM_SRC - 1;
            m_cur  = 0;
            m_bc   = 32'd0;
            m_busy = 1'b0;
            m_lastflag = 1'b0;
        end else begin
            if (m_lastflag) begin
                m_bc++;
                m_last = m_cur;
            end
            if (!m_busy && ((src_ready & src_mask) != 32'd0) && dst_space_ok) begin
                ch    = pick(src_ready & src_mask, m_last);
                m_cur = ch;
                if (HEN != 0) begin
                    e = '{wen: 1'b1, wdata: 16'hA000 | 16'(ch), rd_ch: -1, last: 1'b0};
                    m_q.push_back(e);
                end
                for (int k = 0; k < BL; k++) begin
                    e = '{wen: (k > 0), wdata: (k > 0) ? src_word(ch, m_ptr[ch] + k - 1) : 16'd0,
                          rd_ch: ch, last: 1'b0};
                    m_q.push_back(e);
                end
                e = '{wen: 1'b1, wdata: src_word(ch, m_ptr[ch] + BL - 1), rd_ch: -1, last: 1'b1};
                m_q.push_back(e);
                m_ptr[ch] += BL;
            end
        end
    endtask

    // Compare every DUT output against the model's expectation for this cycle
    task automatic check_cycle();
        exp_t        e;
        logic [31:0] exp_rd;
        if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_busy = 1'b1;
        end else begin
            e = '{wen: 1'b0, wdata: 16'd0, rd_ch: -1, last: 1'b0};
            m_busy = 1'b0;
        end
        m_lastflag = e.last;
        exp_rd = (e.rd_ch >= 0) ? (32'd1 << e.rd_ch) : 32'd0;
        chk("dst_wen", 32'(dst_wen), 32'(e.wen));
        if (e.wen) chk("dst_wdata", 32'(dst_wdata), 32'(e.wdata));
        chk("src_rd_en", src_rd_en, exp_rd);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("cur_id", 32'(cur_id), 32'(m_cur));
        chk("burst_count", burst_count, m_bc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_cycle();
        if (dst_wen) wen_seen++;
    endtask

    task automatic drain();
        src_ready = 32'd0;
        for (int i = 0; i < 40 && busy; i++) step();
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic        rst_first;
        logic [31:0] ready;
        logic [31:0] mask;
        logic        space;
        int          cycles;
        int          exp_delta;
        int          exp_id;
    } row_t;

    row_t rows [8];

    initial begin
        logic [31:0] base;

        rows[0] = '{1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 18, 1, 0};
        rows[1] = '{1'b1, 32'h8000_0005, 32'hFFFF_FFFF, 1'b1, 90, 5, 2};
        rows[2] = '{1'b0, 32'h0000_0003, 32'h0000_0002, 1'b1, 36, 2, 1};
        rows[3] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 20, 0, 1};
        rows[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 20, 0, 1};
        rows[5] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 36, 2, 3};
        rows[6] = '{1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 1'b1, 36, 2, 31};
        rows[7] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 18, 1, 0};

        rst_n = 1'b0;
        src_ready = 32'd0;
        src_mask = 32'd0;
        dst_space_ok = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;

        // Table-driven scenarios: burst count delta and final cur_id per row
        for (int r = 0; r < 8; r++) begin
            if (rows[r].rst_first) begin
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
            base = m_bc;
            src_ready = rows[r].ready;
            src_mask = rows[r].mask;
            dst_space_ok = rows[r].space;
            for (int c = 0; c < rows[r].cycles; c++) step();
            drain();
            chk($sformatf("row%0d_bursts", r), burst_count - base, 32'(rows[r].exp_delta));
            chk($sformatf("row%0d_cur_id", r), 32'(cur_id), 32'(rows[r].exp_id));
        end

        // No space: nothing starts; space arrives, burst starts at the next edge
        src_ready = 32'h1;
        src_mask = 32'hFFFF_FFFF;
        dst_space_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("nospace_busy", 32'(busy), 32'd0);
        end
        dst_space_ok = 1'b1;
        step();
        chk("space_start_busy", 32'(busy), 32'd1);
        chk("space_start_hdr", 32'(dst_wdata), 32'h0000_A000);
        drain();

        // Inputs withdrawn at READ counter 5: burst still completes in full
        src_ready = 32'h1;
        dst_space_ok = 1'b1;
        base = m_bc;
        wen_seen = 0;
        for (int i = 0; i < 7; i++) step();
        src_ready = 32'd0;
        dst_space_ok = 1'b0;
        drain();
        chk("drop_wen_pulses", 32'(wen_seen), 32'(BL + HEN));
        chk("drop_bursts", burst_count - base, 32'd1);

        // Reset at READ counter 7: everything clears, then channel 0 wins first
        src_ready = 32'hFFFF_FFFF;
        dst_space_ok = 1'b1;
        for (int i = 0; i < 9; i++) step();
        chk("pre_rst_rd_en", src_rd_en, 32'h2);
        rst_n = 1'b0;
        step();
        chk("rst_rd_en", src_rd_en, 32'd0);
        chk("rst_wen", 32'(dst_wen), 32'd0);
        chk("rst_wdata", 32'(dst_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcount", burst_count, 32'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_rd_en", src_rd_en, 32'h1);
        drain();

        // Random traffic against the model
        for (int i = 0; i < 1200; i++) begin
            src_ready = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & $urandom);
            src_mask = $urandom | $urandom;
            dst_space_ok = ($urandom_range(0, 9) < 8);
            step();
        end
        dst_space_ok = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
